// File: rtl/grant_bus_xfer_ctrl_pkg.sv
// Shared types for the grant-driven bus transfer controller: FSM states,
// owner index type and the grant decoder used when IDLE accepts a grant.
package bus_ctrl_pkg;

    localparam int NUM_CPU = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    typedef logic [1:0] owner_t;

    typedef struct packed {
        logic   any;
        logic   multi;
        owner_t idx;
    } grant_dec_t;

    // Multi-hot is detected by clearing the lowest set bit and testing the rest.
    function automatic grant_dec_t decode_grant(input logic [NUM_CPU-1:0] oh);
        grant_dec_t r;
        r.any   = |oh;
        r.multi = |(oh & (oh - NUM_CPU'(1)));
        r.idx   = 2'd0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (oh[i]) begin
                r.idx = owner_t'(i);
            end else begin
                r.idx = r.idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/grant_bus_xfer_ctrl_if.sv
// Shared slave bus: one beat per valid/ready handshake, read data returned
// in the accepting cycle.
interface grant_bus_xfer_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);

    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );

endinterface

// File: rtl/grant_bus_xfer_ctrl_watchdog.sv
// Beat watchdog: counts stalled cycles and flags the TIMEOUT-th one so the
// controller can abort in that same cycle.
module bus_ctrl_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over counting a stalled cycle.
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/grant_bus_xfer_ctrl.sv
// Consumes the arbiter's one-hot grant, captures the winner's descriptor and
// runs a non-preemptable multi-beat transfer on the shared slave bus.
module grant_bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CPU-1:0]        grant,
    input  logic [NUM_CPU*ADDR_W-1:0] cpu_addr,
    input  logic [NUM_CPU*LEN_W-1:0]  cpu_len,
    input  logic [NUM_CPU-1:0]        cpu_we,
    input  logic [NUM_CPU*DATA_W-1:0] cpu_wdata,
    grant_bus_xfer_ctrl_if.master     bus,
    output logic [NUM_CPU-1:0]        cpu_ack,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic [NUM_CPU-1:0]        cpu_done,
    output logic [NUM_CPU-1:0]        cpu_err,
    output logic                      busy,
    output logic                      grant_err
);

    state_e              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                we_q, we_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NUM_CPU-1:0]  cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [NUM_CPU-1:0]  cpu_done_q, cpu_done_d;
    logic [NUM_CPU-1:0]  cpu_err_q, cpu_err_d;
    logic                busy_q, busy_d;
    logic                grant_err_q, grant_err_d;

    grant_dec_t          gdec_s;
    logic                xfer_s;
    logic                beat_fire_s;
    logic                wd_clear_s;
    logic                wd_expired_s;

    assign gdec_s      = decode_grant(grant);
    assign xfer_s      = (state_q == ST_XFER);
    assign beat_fire_s = xfer_s && bus.bus_ready;

    bus_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (xfer_s && !bus.bus_ready),
        .expired (wd_expired_s)
    );

    // Next-state, descriptor capture and output pulse generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        len_d       = len_q;
        we_d        = we_q;
        beat_cnt_d  = beat_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 4'b0000;
        cpu_done_d  = 4'b0000;
        cpu_err_d   = 4'b0000;
        grant_err_d = 1'b0;
        wd_clear_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gdec_s.multi) begin
                    grant_err_d = 1'b1;
                end else if (gdec_s.any) begin
                    owner_d    = gdec_s.idx;
                    addr_d     = cpu_addr[gdec_s.idx*ADDR_W +: ADDR_W];
                    len_d      = cpu_len[gdec_s.idx*LEN_W +: LEN_W];
                    we_d       = cpu_we[gdec_s.idx];
                    beat_cnt_d = '0;
                    wd_clear_s = 1'b1;
                    state_d    = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_XFER: begin
                if (beat_fire_s) begin
                    cpu_ack_d[owner_q] = 1'b1;
                    if (!we_q) begin
                        cpu_rdata_d = bus.bus_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    wd_clear_s = 1'b1;
                    // done/err are registered, so they are raised on entry to DONE
                    if (beat_cnt_q == len_q) begin
                        cpu_done_d[owner_q] = 1'b1;
                        state_d             = ST_DONE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (wd_expired_s) begin
                    cpu_done_d[owner_q] = 1'b1;
                    cpu_err_d[owner_q]  = 1'b1;
                    state_d             = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end

            ST_DONE: begin
                state_d = ST_HOLD;
            end

            // One dead cycle lets the arbiter's stale grant drain.
            ST_HOLD: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, descriptor and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 2'd0;
            addr_q      <= '0;
            len_q       <= '0;
            we_q        <= 1'b0;
            beat_cnt_q  <= '0;
            cpu_ack_q   <= 4'b0000;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 4'b0000;
            cpu_err_q   <= 4'b0000;
            busy_q      <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            we_q        <= we_d;
            beat_cnt_q  <= beat_cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            busy_q      <= busy_d;
            grant_err_q <= grant_err_d;
        end
    end

    // Bus side is a decode of the state register, so reset drops it at once.
    assign bus.bus_valid = xfer_s;
    assign bus.bus_we    = xfer_s ? we_q : 1'b0;
    assign bus.bus_addr  = xfer_s ? (addr_q + ADDR_W'(beat_cnt_q)) : '0;
    assign bus.bus_wdata = xfer_s ? cpu_wdata[owner_q*DATA_W +: DATA_W] : '0;

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign busy      = busy_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_grant_bus_xfer_ctrl.sv
// Directed bench for grant_bus_xfer_ctrl: one task per scenario, expected
// values written out by hand per cycle.
module tb_grant_bus_xfer_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   grant = 4'b0000;
    logic [63:0]  cpu_addr = 64'h0;
    logic [11:0]  cpu_len = 12'h0;
    logic [3:0]   cpu_we = 4'b0000;
    logic [127:0] cpu_wdata = 128'h0;
    logic [3:0]   cpu_ack, cpu_done, cpu_err;
    logic [31:0]  cpu_rdata;
    logic         busy, grant_err;

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] exp_v;
    logic [31:0] obs;

    grant_bus_xfer_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    grant_bus_xfer_ctrl #(
        .DATA_W(32), .ADDR_W(16), .LEN_W(3), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .grant(grant),
        .cpu_addr(cpu_addr), .cpu_len(cpu_len), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .bus(bus),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .busy(busy), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    // {valid, we, addr[15:0], ack[3:0], done[3:0], err[3:0], busy, grant_err}
    assign obs = {bus.bus_valid, bus.bus_we, bus.bus_addr, cpu_ack, cpu_done, cpu_err, busy, grant_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.bus_ready = 1'b1;
        bus.bus_rdata = 32'h0;
        #12;
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL reset_obs got=%h exp=%h", obs, 32'h0); end
        n_run++; if (bus.bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=%h", bus.bus_wdata, 32'h0); end
        n_run++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", cpu_rdata, 32'h0); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        cpu_addr[32 +: 16] = 16'h0010;
        cpu_len[6 +: 3]    = 3'd3;
        cpu_we[2]          = 1'b1;
        bus.bus_ready      = 1'b1;
        grant              = 4'b0100;
        tick();
        for (int b = 0; b < 4; b++) begin
            cpu_wdata[64 +: 32] = 32'hA5A5_0000 + 32'(b);
            #1;
            exp_v = {1'b1, 1'b1, 16'h0010 + 16'(b), (b == 0) ? 4'b0000 : 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0};
            n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL wr_beat%0d got=%h exp=%h", b, obs, exp_v); end
            n_run++; if (bus.bus_wdata !== 32'hA5A5_0000 + 32'(b)) begin n_fail++; $display("FAIL wr_wdata%0d got=%h exp=%h", b, bus.bus_wdata, 32'hA5A5_0000 + 32'(b)); end
            tick();
        end
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL wr_done got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL wr_hold got=%h exp=%h", obs, exp_v); end
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL wr_idle got=%h exp=%h", obs, 32'h0); end
        grant = 4'b0000;
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL wr_no_dup got=%h exp=%h", obs, 32'h0); end
    endtask

    task automatic test_read_wrap_wait();
        cpu_addr[16 +: 16] = 16'hFFFF;
        cpu_len[3 +: 3]    = 3'd1;
        cpu_we[1]          = 1'b0;
        bus.bus_ready      = 1'b0;
        grant              = 4'b0010;
        tick();
        for (int w = 0; w < 3; w++) begin
            exp_v = {1'b1, 1'b0, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
            n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rd_wait%0d got=%h exp=%h", w, obs, exp_v); end
            if (w < 2) tick();
        end
        bus.bus_ready = 1'b1;
        bus.bus_rdata = 32'h1111_2222;
        tick();
        exp_v = {1'b1, 1'b0, 16'h0000, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rd_wrap got=%h exp=%h", obs, exp_v); end
        n_run++; if (cpu_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL rd_data0 got=%h exp=%h", cpu_rdata, 32'h1111_2222); end
        bus.bus_rdata = 32'h3333_4444;
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rd_done got=%h exp=%h", obs, exp_v); end
        n_run++; if (cpu_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL rd_data1 got=%h exp=%h", cpu_rdata, 32'h3333_4444); end
        grant = 4'b0000;
        tick();
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL rd_idle got=%h exp=%h", obs, 32'h0); end
    endtask

    task automatic test_no_preempt();
        cpu_addr[0 +: 16]  = 16'h0100;
        cpu_len[0 +: 3]    = 3'd2;
        cpu_we[0]          = 1'b1;
        cpu_addr[48 +: 16] = 16'h0300;
        cpu_len[9 +: 3]    = 3'd0;
        cpu_we[3]          = 1'b1;
        bus.bus_ready      = 1'b1;
        grant              = 4'b0001;
        tick();
        exp_v = {1'b1, 1'b1, 16'h0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_beat0 got=%h exp=%h", obs, exp_v); end
        grant = 4'b1000;
        tick();
        exp_v = {1'b1, 1'b1, 16'h0101, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_beat1 got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = {1'b1, 1'b1, 16'h0102, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_beat2 got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_done0 got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_hold got=%h exp=%h", obs, exp_v); end
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL np_idle got=%h exp=%h", obs, 32'h0); end
        tick();
        exp_v = {1'b1, 1'b1, 16'h0300, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_cpu3 got=%h exp=%h", obs, exp_v); end
        grant = 4'b0000;
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL np_done3 got=%h exp=%h", obs, exp_v); end
        tick();
        tick();
    endtask

    task automatic test_multi_hot();
        grant = 4'b0011;
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL mh_err got=%h exp=%h", obs, exp_v); end
        grant = 4'b0000;
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL mh_idle got=%h exp=%h", obs, 32'h0); end
    endtask

    task automatic test_timeout();
        cpu_addr[32 +: 16] = 16'h0010;
        cpu_len[6 +: 3]    = 3'd3;
        cpu_we[2]          = 1'b1;
        bus.bus_ready      = 1'b0;
        grant              = 4'b0100;
        tick();
        grant = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            exp_v = {1'b1, 1'b1, 16'h0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
            n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_stall%0d got=%h exp=%h", c, obs, exp_v); end
            tick();
        end
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_done got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_hold got=%h exp=%h", obs, exp_v); end
        tick();
        bus.bus_ready = 1'b1;
    endtask

    task automatic test_reset_mid_xfer();
        cpu_addr[0 +: 16] = 16'h0020;
        cpu_len[0 +: 3]   = 3'd3;
        cpu_we[0]         = 1'b0;
        bus.bus_ready     = 1'b1;
        bus.bus_rdata     = 32'h5555_AAAA;
        grant             = 4'b0001;
        tick();
        tick();
        exp_v = {1'b1, 1'b0, 16'h0021, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_beat1 got=%h exp=%h", obs, exp_v); end
        n_run++; if (cpu_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL rst_rdata got=%h exp=%h", cpu_rdata, 32'h5555_AAAA); end
        #2;
        reset = 1'b1;
        #1;
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL rst_async got=%h exp=%h", obs, 32'h0); end
        n_run++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata0 got=%h exp=%h", cpu_rdata, 32'h0); end
        grant = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        n_run++; if (obs !== 32'h0) begin n_fail++; $display("FAIL rst_no_done got=%h exp=%h", obs, 32'h0); end
        cpu_addr[48 +: 16] = 16'h0040;
        cpu_len[9 +: 3]    = 3'd0;
        cpu_we[3]          = 1'b0;
        bus.bus_rdata      = 32'hDEAD_BEEF;
        grant              = 4'b1000;
        tick();
        exp_v = {1'b1, 1'b0, 16'h0040, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_new_beat got=%h exp=%h", obs, exp_v); end
        grant = 4'b0000;
        tick();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0};
        n_run++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_new_done got=%h exp=%h", obs, exp_v); end
        n_run++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_new_rdata got=%h exp=%h", cpu_rdata, 32'hDEAD_BEEF); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap_wait();
        test_no_preempt();
        test_multi_hot();
        test_timeout();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
